// File: rtl/arb_req_fifo_bank.sv
// rtl/arb_req_fifo_bank.sv - per-source request FIFOs feeding the fixed-priority arbiter
// Each lane is an independent FIFO; handshake flags decode only from registered counts.
module arb_req_fifo_bank #(
    parameter type PLD_TYPE = logic,
    parameter int  WIDTH    = 3,
    parameter int  DEPTH    = 4,
    parameter int  CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_vld,
    output logic [WIDTH-1:0] in_rdy,
    input  PLD_TYPE          in_pld  [WIDTH],
    output logic [WIDTH-1:0] v_vld_s,
    input  logic [WIDTH-1:0] v_rdy_s,
    output PLD_TYPE          v_pld_s [WIDTH],
    output logic [CNT_W-1:0] v_cnt   [WIDTH]
);

    localparam int PTR_W = $clog2(DEPTH);

    for (genvar g = 0; g < WIDTH; g++) begin : g_lane
        logic [PTR_W-1:0] r_wr_ptr;
        logic [PTR_W-1:0] r_rd_ptr;
        logic [CNT_W-1:0] r_cnt;
        PLD_TYPE          r_mem [DEPTH];

        logic             w_push;
        logic             w_pop;
        logic [PTR_W-1:0] w_wr_ptr_nxt;
        logic [PTR_W-1:0] w_rd_ptr_nxt;
        logic [CNT_W-1:0] w_cnt_nxt;

        assign in_rdy[g]  = (r_cnt != CNT_W'(DEPTH));
        assign v_vld_s[g] = (r_cnt != '0);
        assign v_pld_s[g] = r_mem[r_rd_ptr];
        assign v_cnt[g]   = r_cnt;

        assign w_push = in_vld[g] & in_rdy[g];
        assign w_pop  = v_vld_s[g] & v_rdy_s[g];

        // Explicit wrap so DEPTH need not be a power of two
        assign w_wr_ptr_nxt = (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
        assign w_rd_ptr_nxt = (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);

        always_comb begin
            w_cnt_nxt = r_cnt;
            case ({w_push, w_pop})
                2'b10:   w_cnt_nxt = r_cnt + CNT_W'(1);
                2'b01:   w_cnt_nxt = r_cnt - CNT_W'(1);
                default: w_cnt_nxt = r_cnt;
            endcase
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_cnt    <= '0;
            end else begin
                if (w_push) r_wr_ptr <= w_wr_ptr_nxt;
                if (w_pop)  r_rd_ptr <= w_rd_ptr_nxt;
                r_cnt <= w_cnt_nxt;
            end
        end

        // Storage carries no reset; validity comes solely from r_cnt
        always_ff @(posedge clk) begin
            if (w_push) r_mem[r_wr_ptr] <= in_pld[g];
        end
    end

endmodule

// File: tb/tb_arb_req_fifo_bank.sv
// tb/tb_arb_req_fifo_bank.sv - directed vector bench for arb_req_fifo_bank
module tb_arb_req_fifo_bank;

    localparam int WIDTH = 3;
    localparam int DEPTH = 4;
    localparam int CNT_W = 3;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] in_vld;
    logic [WIDTH-1:0] in_rdy;
    logic [7:0]       in_pld  [WIDTH];
    logic [WIDTH-1:0] v_vld_s;
    logic [WIDTH-1:0] v_rdy_s;
    logic [7:0]       v_pld_s [WIDTH];
    logic [CNT_W-1:0] v_cnt   [WIDTH];

    int checks = 0;
    int errors = 0;

    arb_req_fifo_bank #(
        .PLD_TYPE(logic [7:0]),
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .in_vld (in_vld),
        .in_rdy (in_rdy),
        .in_pld (in_pld),
        .v_vld_s(v_vld_s),
        .v_rdy_s(v_rdy_s),
        .v_pld_s(v_pld_s),
        .v_cnt  (v_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] vld;
        logic [7:0] p0, p1, p2;
        logic [2:0] rdy;
        logic [2:0] e_rdy;
        logic [2:0] e_vld;
        logic [2:0] c0, c1, c2;
        logic [7:0] h0, h1, h2;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [2:0] vld, input logic [7:0] p0, input logic [7:0] p1,
                                input logic [7:0] p2, input logic [2:0] rdy, input logic [2:0] e_rdy,
                                input logic [2:0] e_vld, input logic [2:0] c0, input logic [2:0] c1,
                                input logic [2:0] c2, input logic [7:0] h0, input logic [7:0] h1,
                                input logic [7:0] h2);
        vec_t v;
        v.vld = vld; v.p0 = p0; v.p1 = p1; v.p2 = p2; v.rdy = rdy;
        v.e_rdy = e_rdy; v.e_vld = e_vld;
        v.c0 = c0; v.c1 = c1; v.c2 = c2;
        v.h0 = h0; v.h1 = h1; v.h2 = h2;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_empty(input string tag);
        chk({tag, " v_vld_s"}, 32'(v_vld_s), 32'h0);
        chk({tag, " in_rdy"}, 32'(in_rdy), 32'h7);
        for (int i = 0; i < WIDTH; i++)
            chk($sformatf("%s cnt%0d", tag, i), 32'(v_cnt[i]), 32'h0);
    endtask

    task automatic apply(input vec_t v, input int idx);
        in_vld    = v.vld;
        in_pld[0] = v.p0;
        in_pld[1] = v.p1;
        in_pld[2] = v.p2;
        v_rdy_s   = v.rdy;
        step();
        chk($sformatf("v%0d in_rdy", idx), 32'(in_rdy), 32'(v.e_rdy));
        chk($sformatf("v%0d v_vld_s", idx), 32'(v_vld_s), 32'(v.e_vld));
        chk($sformatf("v%0d cnt0", idx), 32'(v_cnt[0]), 32'(v.c0));
        chk($sformatf("v%0d cnt1", idx), 32'(v_cnt[1]), 32'(v.c1));
        chk($sformatf("v%0d cnt2", idx), 32'(v_cnt[2]), 32'(v.c2));
        if (v.e_vld[0]) chk($sformatf("v%0d head0", idx), 32'(v_pld_s[0]), 32'(v.h0));
        if (v.e_vld[1]) chk($sformatf("v%0d head1", idx), 32'(v_pld_s[1]), 32'(v.h1));
        if (v.e_vld[2]) chk($sformatf("v%0d head2", idx), 32'(v_pld_s[2]), 32'(v.h2));
    endtask

    initial begin
        // Lane 0 fill, rejected 5th push, in-order drain, pop on empty ignored
        tbl.push_back(mk(3'b001, 8'hA0, 0, 0, 3'b000, 3'b111, 3'b001, 1, 0, 0, 8'hA0, 0, 0));
        tbl.push_back(mk(3'b001, 8'hA1, 0, 0, 3'b000, 3'b111, 3'b001, 2, 0, 0, 8'hA0, 0, 0));
        tbl.push_back(mk(3'b001, 8'hA2, 0, 0, 3'b000, 3'b111, 3'b001, 3, 0, 0, 8'hA0, 0, 0));
        tbl.push_back(mk(3'b001, 8'hA3, 0, 0, 3'b000, 3'b110, 3'b001, 4, 0, 0, 8'hA0, 0, 0));
        tbl.push_back(mk(3'b001, 8'hA4, 0, 0, 3'b000, 3'b110, 3'b001, 4, 0, 0, 8'hA0, 0, 0));
        tbl.push_back(mk(3'b000, 0, 0, 0, 3'b001, 3'b111, 3'b001, 3, 0, 0, 8'hA1, 0, 0));
        tbl.push_back(mk(3'b000, 0, 0, 0, 3'b001, 3'b111, 3'b001, 2, 0, 0, 8'hA2, 0, 0));
        tbl.push_back(mk(3'b000, 0, 0, 0, 3'b001, 3'b111, 3'b001, 1, 0, 0, 8'hA3, 0, 0));
        tbl.push_back(mk(3'b000, 0, 0, 0, 3'b001, 3'b111, 3'b000, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(3'b000, 0, 0, 0, 3'b111, 3'b111, 3'b000, 0, 0, 0, 0, 0, 0));
        // Lane 1 simultaneous push/pop at cnt=1, long enough to wrap pointers
        tbl.push_back(mk(3'b010, 0, 8'h11, 0, 3'b000, 3'b111, 3'b010, 0, 1, 0, 0, 8'h11, 0));
        tbl.push_back(mk(3'b010, 0, 8'h12, 0, 3'b010, 3'b111, 3'b010, 0, 1, 0, 0, 8'h12, 0));
        for (int k = 0; k < 10; k++)
            tbl.push_back(mk(3'b010, 0, 8'(8'h13 + k), 0, 3'b010, 3'b111, 3'b010, 0, 1, 0,
                             0, 8'(8'h13 + k), 0));
        tbl.push_back(mk(3'b000, 0, 0, 0, 3'b010, 3'b111, 3'b000, 0, 0, 0, 0, 0, 0));

        rst_n   = 1'b0;
        in_vld  = 3'b111;
        v_rdy_s = 3'b000;
        for (int i = 0; i < WIDTH; i++) in_pld[i] = 8'hEE;
        step();
        step();
        chk_empty("reset");

        @(negedge clk);
        rst_n  = 1'b1;
        in_vld = 3'b000;
        step();
        chk_empty("post_reset");

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

        // Lane 2 full with push and pop in the same cycle
        v_rdy_s = 3'b000;
        for (int i = 0; i < DEPTH; i++) begin
            in_vld    = 3'b100;
            in_pld[2] = 8'(8'hC0 + i);
            step();
            chk($sformatf("fill2 cnt%0d", i), 32'(v_cnt[2]), 32'(i + 1));
        end
        chk("full2 in_rdy", 32'(in_rdy[2]), 32'h0);
        chk("full2 head", 32'(v_pld_s[2]), 32'hC0);
        in_vld    = 3'b100;
        in_pld[2] = 8'hC4;
        v_rdy_s   = 3'b100;
        step();
        chk("fullpop cnt2", 32'(v_cnt[2]), 32'h3);
        chk("fullpop in_rdy", 32'(in_rdy[2]), 32'h1);
        chk("fullpop head", 32'(v_pld_s[2]), 32'hC1);
        v_rdy_s = 3'b000;
        step();
        chk("repush cnt2", 32'(v_cnt[2]), 32'h4);
        chk("repush in_rdy", 32'(in_rdy[2]), 32'h0);
        in_vld  = 3'b000;
        v_rdy_s = 3'b100;
        for (int i = 0; i < DEPTH; i++) begin
            chk($sformatf("drain2 head%0d", i), 32'(v_pld_s[2]), 32'(8'hC1 + i));
            step();
        end
        chk("drain2 cnt", 32'(v_cnt[2]), 32'h0);
        chk("drain2 vld", 32'(v_vld_s[2]), 32'h0);

        // Partial fill to counts 2,3,1 then asynchronous reset mid-cycle
        v_rdy_s = 3'b000;
        in_vld  = 3'b111;
        step();
        in_vld = 3'b011;
        step();
        in_vld = 3'b010;
        step();
        in_vld = 3'b000;
        chk("mid cnt0", 32'(v_cnt[0]), 32'h2);
        chk("mid cnt1", 32'(v_cnt[1]), 32'h3);
        chk("mid cnt2", 32'(v_cnt[2]), 32'h1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_empty("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk_empty("after_async");

        in_vld    = 3'b001;
        in_pld[0] = 8'h5A;
        step();
        in_vld = 3'b000;
        chk("restart cnt0", 32'(v_cnt[0]), 32'h1);
        chk("restart head0", 32'(v_pld_s[0]), 32'h5A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/arb_req_fifo_bank.md
Name: arb_req_fifo_bank

Overview:
Per-requester buffering stage that sits directly upstream of the fixed-priority arbiter. It holds WIDTH independent FIFOs, one per source. Each FIFO accepts a valid/ready request stream from its source and presents its head entry as one lane of the arbiter's v_vld_s/v_rdy_s/v_pld_s vector. Low-priority sources can therefore queue while higher-priority sources win, without back-pressuring their producers immediately.

Parameters:
PLD_TYPE, logic, payload type carried per entry (same type as the arbiter's payload).
WIDTH, 3, number of sources/lanes; must be >= 1 and must equal the arbiter's WIDTH.
DEPTH, 4, entries per lane FIFO; must be >= 2; a power of 2 is not required.
CNT_W, $clog2(DEPTH+1), width of each occupancy count (derived; do not override).

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst_n  input  1  asynchronous active-low reset.
in_vld  input  [WIDTH-1:0]  per-source request valid.
in_rdy  output  [WIDTH-1:0]  per-source ready; lane i FIFO not full.
in_pld  input  PLD_TYPE [WIDTH-1:0] (unpacked)  per-source payload.
v_vld_s  output  [WIDTH-1:0]  lane i head entry valid (to arbiter v_vld_s).
v_rdy_s  input  [WIDTH-1:0]  lane i head consumed (from arbiter v_rdy_s).
v_pld_s  output  PLD_TYPE [WIDTH-1:0] (unpacked)  lane i head payload.
v_cnt  output  [CNT_W-1:0] [WIDTH-1:0] (unpacked)  lane i occupancy, 0..DEPTH.

Behaviour:
- Clock, reset and registers:
  - Single clock domain.
  - rst_n is asynchronous assert, synchronous deassert (provided externally).
  - While rst_n=0: all write pointers, read pointers and counts are 0, so v_vld_s=0, v_cnt=0 and in_rdy='1.
  - Writes presented during reset are discarded.
  - Storage array is not reset. v_pld_s is don't-care whenever v_vld_s[i]=0.
- Lanes are fully independent; no cross-lane state.
- Per lane i:
  - push = in_vld[i] & in_rdy[i].
  - pop = v_vld_s[i] & v_rdy_s[i].
  - in_rdy[i] = (cnt[i] != DEPTH). Decoded from registered count only; no combinational path from v_rdy_s or in_vld.
  - v_vld_s[i] = (cnt[i] != 0). Decoded from registered count only.
  - v_pld_s[i] = mem[i][rd_ptr[i]] (head-of-queue read, combinational from registered pointer and storage).
- Update rules per lane:
  - On push: mem[wr_ptr] <= in_pld[i]; wr_ptr advances.
  - On pop: rd_ptr advances.
  - Pointer advance: from DEPTH-1 to 0, otherwise +1 (explicit wrap; no reliance on power-of-2 overflow).
  - cnt <= cnt + push - pop, so simultaneous push and pop leaves cnt unchanged.
- Latency:
  - Entry pushed at edge N is visible on v_vld_s/v_pld_s after edge N (earliest pop at edge N+1).
  - No write-to-read bypass. Minimum buffer latency is 1 cycle.
- Boundary conditions:
  - Full (cnt=DEPTH): in_rdy=0, so push is impossible even if a pop occurs the same cycle. in_rdy reasserts the cycle after a pop.
  - Empty (cnt=0): v_vld_s=0, so pop is impossible. v_rdy_s asserted on an empty lane is ignored.
  - Simultaneous push and pop at cnt=1: the head is popped, the new entry is written, cnt stays 1, and the head becomes the new entry. Ordering is strictly FIFO.
  - Reset asserted mid-operation: all lanes empty immediately (asynchronous); in-flight contents are lost.
- Ordering guarantee: per-lane FIFO order is preserved. No ordering is promised between lanes; that is the arbiter's job.

Test Plan:
- Reset: hold rst_n=0 with in_vld='1 -> v_vld_s=0, v_cnt all 0, in_rdy='1. After release, no entries are present.
- Fill lane 0 (WIDTH=3, DEPTH=4): push 0xA0..0xA3 on consecutive cycles with v_rdy_s=0 -> v_cnt[0] steps 1,2,3,4; in_rdy[0]=0 after the 4th push. A 5th push (0xA4) is rejected, and lanes 1 and 2 are unaffected.
- Drain lane 0 in order: after the fill, v_rdy_s[0]=1 for 4 cycles -> v_pld_s[0] shows 0xA0,0xA1,0xA2,0xA3; v_vld_s[0] drops after the 4th pop; in_rdy[0]=1 the cycle after the 1st pop.
- Simultaneous push/pop: lane 1 at cnt=1 (head 0x11), push 0x12 with v_rdy_s[1]=1 -> cnt stays 1 and the next head is 0x12. Repeating for 10 cycles exercises pointer wrap; data order is preserved.
- Full plus pop: lane 2 full, in_vld[2]=1 and v_rdy_s[2]=1 in the same cycle -> only the pop happens, cnt goes 4->3, and the push is accepted next cycle.
- Reset mid-stream: lanes partially full (cnt = 2,3,1), assert rst_n=0 asynchronously mid-cycle -> v_vld_s=0 and v_cnt=0 immediately, before the next clk edge.
